quire_acc: RTL



---
 rtl/quire_acc_pkg.sv | 28 ++
 rtl/quire_align.sv | 50 +++++
 rtl/quire_acc.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/quire_acc_pkg.sv
// Shared quire sizing helpers and flag bundle for the posit exact-dot-product path.
package quire_acc_pkg;

    typedef struct packed {
        logic nar;
        logic ovf;
        logic sign;
        logic zero;
    } quire_flags_t;

    function automatic int quire_size(input int n, input int es, input int log_nb);
        return ((32'sd1 <<< (es + 32'sd2)) * (n - 32'sd2)) + 32'sd1 + log_nb;
    endfunction

    // Bit position of weight 2^0 inside the quire.
    function automatic int quire_bpp(input int n, input int es);
        return ((32'sd1 <<< (es + 32'sd2)) * (n - 32'sd2)) / 32'sd2;
    endfunction

    function automatic int prod_frac_width(input int n, input int es);
        return 32'sd2 * (n - es - 32'sd2);
    endfunction

    function automatic int prod_scale_width(input int n, input int es);
        return es + 32'sd2 + $clog2(n);
    endfunction

endpackage

// File: rtl/quire_align.sv
// Registered signed barrel shifter placing a product magnitude at its quire position.
module quire_align
    import quire_acc_pkg::*;
#(
    parameter int FRAC_WIDTH  = 10,
    parameter int SCALE_WIDTH = 6,
    parameter int QUIRE_SIZE  = 59,
    parameter int BPP         = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [FRAC_WIDTH-1:0]  fraction,
    input  logic [SCALE_WIDTH-1:0] scale,
    output logic [QUIRE_SIZE-1:0]  aligned
);

    localparam int SH_W = SCALE_WIDTH + $clog2(QUIRE_SIZE) + 2;
    localparam logic [SH_W-1:0] OFFSET = SH_W'(BPP - (FRAC_WIDTH - 32'sd2));

    logic [SH_W-1:0]       scale_ext_s;
    logic [SH_W-1:0]       sh_s;
    logic [SH_W-1:0]       sh_mag_s;
    logic                  sh_neg_s;
    logic [QUIRE_SIZE-1:0] frac_ext_s;
    logic [QUIRE_SIZE-1:0] shifted_s;
    logic [QUIRE_SIZE-1:0] aligned_r;

    // Shift distance in two's complement; negative distances shift right and truncate.
    always_comb begin
        scale_ext_s = {{(SH_W-SCALE_WIDTH){scale[SCALE_WIDTH-1]}}, scale};
        sh_s        = scale_ext_s + OFFSET;
        sh_neg_s    = sh_s[SH_W-1];
        sh_mag_s    = sh_neg_s ? ((~sh_s) + {{(SH_W-1){1'b0}}, 1'b1}) : sh_s;
        frac_ext_s  = {{(QUIRE_SIZE-FRAC_WIDTH){1'b0}}, fraction};
        shifted_s   = sh_neg_s ? (frac_ext_s >> sh_mag_s) : (frac_ext_s << sh_mag_s);
    end

    // Aligned-product register, loaded only on an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aligned_r <= {QUIRE_SIZE{1'b0}};
        end else if (en) begin
            aligned_r <= shifted_s;
        end
    end

    assign aligned = aligned_r;

endmodule

// File: rtl/quire_acc.sv
// Quire accumulator: aligns decoded posit products and sums them exactly per sow/eow window.
module quire_acc
    import quire_acc_pkg::*;
#(
    parameter int POSIT_WIDTH   = 8,
    parameter int ES            = 1,
    parameter int LOG_NB_ACCUM  = 10,
    parameter int FRAC_WIDTH    = prod_frac_width(POSIT_WIDTH, ES),
    parameter int SCALE_WIDTH   = prod_scale_width(POSIT_WIDTH, ES),
    parameter int EMIT_EOW_ONLY = 0,
    localparam int QUIRE_SIZE   = quire_size(POSIT_WIDTH, ES, LOG_NB_ACCUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rts_i,
    output logic                   rtr_o,
    input  logic                   sow_i,
    input  logic                   eow_i,
    input  logic [FRAC_WIDTH-1:0]  fraction_i,
    input  logic [SCALE_WIDTH-1:0] scale_i,
    input  logic                   sign_i,
    input  logic                   zero_i,
    input  logic                   NaR_i,
    input  logic                   rtr_i,
    output logic                   rts_o,
    output logic                   sow_o,
    output logic                   eow_o,
    output logic [QUIRE_SIZE-1:0]  data_o,
    output logic                   sign_o,
    output logic                   zero_o,
    output logic                   NaR_o,
    output logic                   ovf_o
);

    localparam int BPP = quire_bpp(POSIT_WIDTH, ES);
    localparam int QM  = QUIRE_SIZE - 1;

    logic                  process_en_s, accept_s, rtr_r;
    logic                  s1_valid_r, s1_sow_r, s1_eow_r, s1_sign_r, s1_zero_r, s1_nar_r;
    logic [QUIRE_SIZE-1:0] aligned_s, quire_r, base_s, quire_next_s;
    logic [QUIRE_SIZE:0]   base_ext_s, addend_ext_s, sum_ext_s;
    logic                  nar_r, ovf_r, nar_next_s, ovf_next_s;
    logic                  rts_r, sow_r, eow_r;
    quire_flags_t          flags_s;

    assign process_en_s = rtr_i | ~rts_r;
    assign accept_s     = rts_i & rtr_r & process_en_s;

    // Upstream ready is the previous cycle's pipeline enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rtr_r <= 1'b0;
        end else begin
            rtr_r <= process_en_s;
        end
    end

    quire_align #(
        .FRAC_WIDTH (FRAC_WIDTH),
        .SCALE_WIDTH(SCALE_WIDTH),
        .QUIRE_SIZE (QUIRE_SIZE),
        .BPP        (BPP)
    ) u_align (
        .clk     (clk),
        .rst     (rst),
        .en      (accept_s),
        .fraction(fraction_i),
        .scale   (scale_i),
        .aligned (aligned_s)
    );

    // Stage 1 side-band flags travel with the aligned product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sow_r   <= 1'b0;
            s1_eow_r   <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_zero_r  <= 1'b0;
            s1_nar_r   <= 1'b0;
        end else if (process_en_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_sow_r  <= sow_i;
                s1_eow_r  <= eow_i;
                s1_sign_r <= sign_i;
                s1_zero_r <= zero_i;
                s1_nar_r  <= NaR_i;
            end
        end
    end

    // Next quire value; one extra MSB exposes signed overflow, and NaR freezes the sum.
    always_comb begin
        base_s       = s1_sow_r ? {QUIRE_SIZE{1'b0}} : quire_r;
        nar_next_s   = (s1_sow_r ? 1'b0 : nar_r) | s1_nar_r;
        ovf_next_s   = s1_sow_r ? 1'b0 : ovf_r;
        base_ext_s   = {base_s[QM], base_s};
        addend_ext_s = {1'b0, aligned_s};
        sum_ext_s    = s1_sign_r ? (base_ext_s - addend_ext_s) : (base_ext_s + addend_ext_s);
        if (nar_next_s) begin
            quire_next_s = base_s;
        end else if (s1_zero_r) begin
            quire_next_s = base_s;
        end else begin
            quire_next_s = sum_ext_s[QM:0];
            ovf_next_s   = ovf_next_s | (sum_ext_s[QUIRE_SIZE] ^ sum_ext_s[QM]);
        end
    end

    // Stage 2 accumulator and output beat registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quire_r <= {QUIRE_SIZE{1'b0}};
            nar_r   <= 1'b0;
            ovf_r   <= 1'b0;
            sow_r   <= 1'b0;
            eow_r   <= 1'b0;
            rts_r   <= 1'b0;
        end else if (process_en_s) begin
            if (s1_valid_r) begin
                quire_r <= quire_next_s;
                nar_r   <= nar_next_s;
                ovf_r   <= ovf_next_s;
                sow_r   <= s1_sow_r;
                eow_r   <= s1_eow_r;
                rts_r   <= (EMIT_EOW_ONLY != 0) ? s1_eow_r : 1'b1;
            end else begin
                rts_r   <= 1'b0;
            end
        end
    end

    always_comb begin
        flags_s.nar  = nar_r;
        flags_s.ovf  = ovf_r;
        flags_s.sign = quire_r[QM];
        flags_s.zero = ~|quire_r;
    end

    assign rtr_o  = rtr_r;
    assign rts_o  = rts_r;
    assign sow_o  = sow_r;
    assign eow_o  = eow_r;
    assign data_o = quire_r;
    assign sign_o = flags_s.sign;
    assign zero_o = flags_s.zero;
    assign NaR_o  = flags_s.nar;
    assign ovf_o  = flags_s.ovf;

endmodule
